// File: rtl/oneshot_multi.sv
// rtl/oneshot_multi.sv - multi-channel one-shot pulse generator with shared clock enable
// Per-channel edge-triggered pulses with optional retrigger, holdoff, cancel and done strobe.
module oneshot_multi #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 9,
  parameter int CLOCKS    = 16,
  parameter int RETRIGGER = 0,
  parameter int EDGE      = 0,
  parameter int HOLDOFF   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic [CHANNELS-1:0]       trigger,
  input  logic [CHANNELS*WIDTH-1:0] len,
  input  logic [CHANNELS-1:0]       cancel,
  output logic [CHANNELS-1:0]       q,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       busy
);

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  localparam logic [WIDTH-1:0] CLOCKS_W  = WIDTH'(CLOCKS);
  localparam logic [WIDTH-1:0] HOLD_LAST = WIDTH'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);

  state_t              state    [CHANNELS];
  logic [WIDTH-1:0]    cnt      [CHANNELS];
  logic [WIDTH-1:0]    load_val [CHANNELS];
  logic [CHANNELS-1:0] sample;
  logic [CHANNELS-1:0] trig_edge;
  logic                armed;

  // armed stays low for the first ce tick after reset so a held-high trigger never fires
  always_comb begin
    trig_edge = '0;
    if (armed) begin
      if (EDGE == 0)      trig_edge = trigger & ~sample;
      else if (EDGE == 1) trig_edge = sample & ~trigger;
      else                trig_edge = sample ^ trigger;
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      load_val[i] = ((len[i*WIDTH +: WIDTH] == '0) ? CLOCKS_W : len[i*WIDTH +: WIDTH])
                    - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample <= '0;
      armed  <= 1'b0;
      q      <= '0;
      done   <= '0;
      busy   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      done <= '0;
      if (ce) begin
        sample <= trigger;
        armed  <= 1'b1;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (cancel[i]) begin
          state[i] <= IDLE;
          cnt[i]   <= '0;
          q[i]     <= 1'b0;
          busy[i]  <= 1'b0;
        end else if (ce) begin
          case (state[i])
            IDLE: begin
              if (trig_edge[i]) begin
                q[i]     <= 1'b1;
                busy[i]  <= 1'b1;
                cnt[i]   <= load_val[i];
                state[i] <= PULSE;
              end
            end
            PULSE: begin
              if (trig_edge[i] && RETRIGGER == 1) begin
                cnt[i] <= load_val[i];
              end else if (cnt[i] == '0) begin
                q[i]    <= 1'b0;
                done[i] <= 1'b1;
                if (HOLDOFF == 0) begin
                  state[i] <= IDLE;
                  busy[i]  <= 1'b0;
                end else begin
                  state[i] <= HOLD;
                  cnt[i]   <= HOLD_LAST;
                end
              end else begin
                cnt[i] <= cnt[i] - WIDTH'(1);
              end
            end
            HOLD: begin
              if (cnt[i] == '0) begin
                state[i] <= IDLE;
                busy[i]  <= 1'b0;
              end else begin
                cnt[i] <= cnt[i] - WIDTH'(1);
              end
            end
            default: begin
              state[i] <= IDLE;
              q[i]     <= 1'b0;
              busy[i]  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
